// File: rtl/stage4ma_pkg.sv
// Shared decode helpers and constants for the memory-access stage (stage4ma).
// Also holds the WAIT timeout length used when STAGE4MA_TIMEOUT_EN is defined.
package stage4ma_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0]  ISET_BASE      = 4'h0;
  localparam logic [3:0]  OP_LOAD        = 4'hA;
  localparam logic [3:0]  OP_STORE       = 4'hB;
  localparam logic [3:0]  OP_NOP         = 4'hF;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam logic [3:0]  TIMEOUT_LAST   = 4'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] FAULT_RESULT   = 12'hFFF;

  function automatic logic mem_read_fn(input logic [3:0] iset, input logic [3:0] opcode);
    return (iset == ISET_BASE) && (opcode == OP_LOAD);
  endfunction

  function automatic logic mem_write_fn(input logic [3:0] iset, input logic [3:0] opcode);
    return (iset == ISET_BASE) && (opcode == OP_STORE);
  endfunction

  function automatic logic reg_write_fn(input logic [3:0] iset, input logic [3:0] opcode);
    return !mem_write_fn(iset, opcode) && (opcode != OP_NOP);
  endfunction

endpackage

// File: rtl/stage4ma.sv
// Memory-access pipeline stage: forwards ALU results, or runs one load/store bus handshake.
// Optional: define STAGE4MA_TIMEOUT_EN to abort a WAIT with no ack after 16 cycles.
module stage4ma
  import stage4ma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [11:0] pc_in,
  input  logic [11:0] instr_in,
  input  logic [3:0]  instr_set_in,
  input  logic [11:0] result_in,
  input  logic [3:0]  flags_in,
  input  logic [3:0]  reg_waddr_in,
  input  logic [11:0] store_data_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic        enable_out,
  output logic [11:0] pc_out,
  output logic [11:0] instr_out,
  output logic [11:0] result_out,
  output logic [3:0]  instr_set_out,
  output logic [3:0]  flags_out,
  output logic [3:0]  reg_waddr_out,
  output logic        mem_fault
);

  state_t state_r;
  state_t state_next_s;
  logic   flush_sticky_r;
  logic   is_load_s;
  logic   is_store_s;
  logic   is_mem_s;
  logic   accept_s;
  logic   kill_s;
  logic   timeout_s;

  assign is_load_s  = mem_read_fn(instr_set_in, instr_in[11:8]);
  assign is_store_s = mem_write_fn(instr_set_in, instr_in[11:8]);
  assign is_mem_s   = is_load_s | is_store_s;
  assign accept_s   = enable_in & ~flush_in;
  assign kill_s     = flush_in | flush_sticky_r;
  assign stall_out  = (state_r == ST_WAIT);

`ifdef STAGE4MA_TIMEOUT_EN
  logic [3:0] tmo_cnt_r;

  assign timeout_s = (state_r == ST_WAIT) && !mem_ack && (tmo_cnt_r == TIMEOUT_LAST);

  // Count consecutive un-acked WAIT cycles; wraps to zero on the timeout edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= 4'd0;
    end else if ((state_r == ST_WAIT) && !mem_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 4'd1;
    end else begin
      tmo_cnt_r <= 4'd0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mem_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack || timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Registered bus request, write-back bundle and flush bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 12'h000;
      mem_wdata      <= 12'h000;
      enable_out     <= 1'b0;
      pc_out         <= 12'h000;
      instr_out      <= 12'h000;
      result_out     <= 12'h000;
      instr_set_out  <= 4'h0;
      flags_out      <= 4'h0;
      reg_waddr_out  <= 4'h0;
      mem_fault      <= 1'b0;
      flush_sticky_r <= 1'b0;
    end else begin
      mem_fault <= timeout_s;
      case (state_r)
        ST_IDLE: begin
          flush_sticky_r <= 1'b0;
          if (accept_s) begin
            // The bundle is parked in the output registers; enable_out stays low until ack.
            pc_out        <= pc_in;
            instr_out     <= instr_in;
            result_out    <= result_in;
            instr_set_out <= instr_set_in;
            flags_out     <= flags_in;
            reg_waddr_out <= reg_waddr_in;
            enable_out    <= ~is_mem_s;
            mem_req       <= is_mem_s;
            mem_we        <= is_store_s;
            if (is_mem_s) begin
              mem_addr  <= result_in;
              mem_wdata <= store_data_in;
            end
          end else begin
            enable_out <= 1'b0;
            mem_req    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_ack || timeout_s) begin
            mem_req        <= 1'b0;
            enable_out     <= ~kill_s;
            flush_sticky_r <= 1'b0;
            if (timeout_s) begin
              result_out <= FAULT_RESULT;
            end else if (!mem_we) begin
              result_out <= mem_rdata;
            end
          end else begin
            enable_out     <= 1'b0;
            flush_sticky_r <= flush_sticky_r | flush_in;
          end
        end
        default: begin
          mem_req        <= 1'b0;
          enable_out     <= 1'b0;
          flush_sticky_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage4ma.sv
// Randomized self-checking bench for stage4ma against a transaction-level reference model.
// Honours STAGE4MA_TIMEOUT_EN the same way the design does.
module tb_stage4ma;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_in;
  logic [11:0] pc_in, instr_in, result_in, store_data_in, mem_rdata;
  logic [3:0]  instr_set_in, flags_in, reg_waddr_in;
  logic        flush_in, mem_ack;
  logic        stall_out, mem_req, mem_we, enable_out, mem_fault;
  logic [11:0] mem_addr, mem_wdata, pc_out, instr_out, result_out;
  logic [3:0]  instr_set_out, flags_out, reg_waddr_out;

  int errors = 0;
  int checks = 0;

`ifdef STAGE4MA_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  stage4ma dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .pc_in(pc_in), .instr_in(instr_in),
    .instr_set_in(instr_set_in), .result_in(result_in), .flags_in(flags_in),
    .reg_waddr_in(reg_waddr_in), .store_data_in(store_data_in), .flush_in(flush_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .enable_out(enable_out), .pc_out(pc_out), .instr_out(instr_out),
    .result_out(result_out), .instr_set_out(instr_set_out), .flags_out(flags_out),
    .reg_waddr_out(reg_waddr_out), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Reference model state: one outstanding memory transaction at most.
  bit          m_busy, m_flushed, m_load;
  int          m_wait;
  logic [11:0] c_pc, c_instr, c_res;
  logic [3:0]  c_iset, c_flags, c_wa;
  bit          e_en, e_req, e_we, e_stall, e_fault;
  logic [11:0] e_addr, e_wdata, e_pc, e_instr, e_res;
  logic [3:0]  e_iset, e_flags, e_wa;

  function automatic bit op_load(logic [3:0] iset, logic [11:0] instr);
    return iset == 4'h0 && instr[11:8] == 4'hA;
  endfunction

  function automatic bit op_store(logic [3:0] iset, logic [11:0] instr);
    return iset == 4'h0 && instr[11:8] == 4'hB;
  endfunction

  task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_flushed = 0; m_wait = 0;
    e_en = 0; e_req = 0; e_stall = 0; e_fault = 0;
  endtask

  task automatic finish_txn(logic [11:0] res, bit fault);
    e_en = !(m_flushed || flush_in);
    e_pc = c_pc; e_instr = c_instr; e_iset = c_iset; e_flags = c_flags; e_wa = c_wa;
    e_res = res; e_req = 0; e_fault = fault; m_busy = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    e_fault = 0;
    if (!m_busy) begin
      if (enable_in && !flush_in) begin
        c_pc = pc_in; c_instr = instr_in; c_iset = instr_set_in; c_res = result_in;
        c_flags = flags_in; c_wa = reg_waddr_in;
        if (op_load(instr_set_in, instr_in) || op_store(instr_set_in, instr_in)) begin
          m_busy = 1; m_wait = 0; m_flushed = 0;
          m_load = op_load(instr_set_in, instr_in);
          e_en = 0; e_req = 1; e_we = !m_load; e_addr = result_in; e_wdata = store_data_in;
        end else begin
          e_en = 1; e_req = 0;
          e_pc = pc_in; e_instr = instr_in; e_iset = instr_set_in; e_res = result_in;
          e_flags = flags_in; e_wa = reg_waddr_in;
        end
      end else begin
        e_en = 0; e_req = 0;
      end
    end else begin
      m_wait++;
      if (mem_ack) finish_txn(m_load ? mem_rdata : c_res, 1'b0);
      else if (TMO && m_wait == 16) finish_txn(12'hFFF, 1'b1);
      else begin
        m_flushed = m_flushed || flush_in;
        e_en = 0;
      end
    end
    e_stall = m_busy;
  endtask

  task automatic compare();
    chk("enable_out", {11'd0, enable_out}, {11'd0, e_en});
    chk("stall_out", {11'd0, stall_out}, {11'd0, e_stall});
    chk("mem_req", {11'd0, mem_req}, {11'd0, e_req});
    chk("mem_fault", {11'd0, mem_fault}, {11'd0, e_fault});
    if (e_req) begin
      chk("mem_we", {11'd0, mem_we}, {11'd0, e_we});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (e_en) begin
      chk("pc_out", pc_out, e_pc);
      chk("instr_out", instr_out, e_instr);
      chk("result_out", result_out, e_res);
      chk("instr_set_out", {8'd0, instr_set_out}, {8'd0, e_iset});
      chk("flags_out", {8'd0, flags_out}, {8'd0, e_flags});
      chk("reg_waddr_out", {8'd0, reg_waddr_out}, {8'd0, e_wa});
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_op(logic en, logic [3:0] iset, logic [3:0] op, logic [11:0] res, logic [11:0] sd);
    enable_in = en; instr_set_in = iset; instr_in = {op, 8'($urandom)}; result_in = res;
    store_data_in = sd; pc_in = 12'($urandom); flags_in = 4'($urandom); reg_waddr_in = 4'($urandom);
    flush_in = 1'b0; mem_ack = 1'b0; mem_rdata = 12'($urandom);
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    set_op(1'b0, 4'h0, 4'h0, 12'h000, 12'h000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset enable_out", {11'd0, enable_out}, 12'd0);
    chk("reset mem_req", {11'd0, mem_req}, 12'd0);
    chk("reset stall_out", {11'd0, stall_out}, 12'd0);
    chk("reset result_out", result_out, 12'h000);
    chk("reset mem_addr", mem_addr, 12'h000);
    rst = 1'b0;

    // ALU op passes straight through.
    set_op(1'b1, 4'h0, 4'h1, 12'h123, 12'h000);
    step();
    chk("alu enable_out", {11'd0, enable_out}, 12'd1);
    chk("alu result_out", result_out, 12'h123);
    chk("alu mem_req", {11'd0, mem_req}, 12'd0);

    // Load with ack on the fourth WAIT cycle.
    set_op(1'b1, 4'h0, 4'hA, 12'h040, 12'h000);
    step();
    stalls = int'(stall_out);
    for (int i = 0; i < 3; i++) begin
      step();
      stalls += int'(stall_out);
      chk("load addr stable", mem_addr, 12'h040);
    end
    mem_ack = 1'b1; mem_rdata = 12'hABC;
    step();
    chk("load stall cycles", 12'(stalls), 12'd4);
    chk("load result_out", result_out, 12'hABC);
    chk("load enable_out", {11'd0, enable_out}, 12'd1);

    // Store acked in its first WAIT cycle.
    set_op(1'b1, 4'h0, 4'hB, 12'h010, 12'h555);
    step();
    chk("store mem_we", {11'd0, mem_we}, 12'd1);
    chk("store mem_wdata", mem_wdata, 12'h555);
    mem_ack = 1'b1;
    step();
    chk("store enable_out", {11'd0, enable_out}, 12'd1);
    chk("store stall_out", {11'd0, stall_out}, 12'd0);

    // Flush in the second WAIT cycle, ack in the third.
    set_op(1'b1, 4'h0, 4'hA, 12'h077, 12'h000);
    step();
    step();
    flush_in = 1'b1;
    step();
    chk("flushed load mem_req held", {11'd0, mem_req}, 12'd1);
    flush_in = 1'b0; mem_ack = 1'b1;
    step();
    chk("flushed load enable_out", {11'd0, enable_out}, 12'd0);
    chk("flushed load mem_req", {11'd0, mem_req}, 12'd0);

    // Flush in IDLE drops a load before it issues.
    set_op(1'b1, 4'h0, 4'hA, 12'h022, 12'h000);
    flush_in = 1'b1;
    step();
    chk("idle flush mem_req", {11'd0, mem_req}, 12'd0);

`ifdef STAGE4MA_TIMEOUT_EN
    set_op(1'b1, 4'h0, 4'hA, 12'h300, 12'h000);
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 16) chk("timeout still waiting", {11'd0, stall_out}, 12'd1);
    end
    chk("timeout mem_fault", {11'd0, mem_fault}, 12'd1);
    chk("timeout result_out", result_out, 12'hFFF);
    chk("timeout stall_out", {11'd0, stall_out}, 12'd0);
    set_op(1'b0, 4'h0, 4'h0, 12'h000, 12'h000);
    step();
    chk("timeout fault pulse", {11'd0, mem_fault}, 12'd0);
`else
    set_op(1'b1, 4'h0, 4'hA, 12'h300, 12'h000);
    step();
    for (int i = 0; i < 20; i++) step();
    chk("no-timeout still waiting", {11'd0, stall_out}, 12'd1);
    mem_ack = 1'b1;
    step();
`endif

    // Asynchronous reset in the middle of WAIT.
    set_op(1'b1, 4'h0, 4'hB, 12'h0F0, 12'h0AA);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async rst mem_req", {11'd0, mem_req}, 12'd0);
    chk("async rst stall_out", {11'd0, stall_out}, 12'd0);
    chk("async rst mem_we", {11'd0, mem_we}, 12'd0);
    chk("async rst pc_out", pc_out, 12'h000);
    chk("async rst result_out", result_out, 12'h000);
    model_reset();
    #4 rst = 1'b0;
    set_op(1'b0, 4'h0, 4'h0, 12'h000, 12'h000);
    step();

    // Randomized traffic; the bundle is held while stalled.
    for (int c = 0; c < 3000; c++) begin
      if (!m_busy) begin
        int r;
        r = $urandom_range(0, 4);
        enable_in = ($urandom_range(0, 3) != 0);
        instr_set_in = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        instr_in = {(r == 0) ? 4'hA : (r == 1) ? 4'hB : 4'($urandom), 8'($urandom)};
        pc_in = 12'($urandom); result_in = 12'($urandom); store_data_in = 12'($urandom);
        flags_in = 4'($urandom); reg_waddr_in = 4'($urandom);
      end
      flush_in = ($urandom_range(0, 9) == 0);
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = 12'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage4ma.md
STAGE4MA -- requirements
Module: stage4ma

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 enable_in  in  1  valid instruction presented by execute stage.
REQ-004 pc_in, instr_in  in  12 each; instr_set_in in 4; result_in in 12 (ALU result, also memory address); flags_in in 4; reg_waddr_in in 4.
REQ-005 store_data_in  in  12  data for store instructions.
REQ-006 flush_in  in  1  kill the instruction held or presented this cycle.
REQ-007 stall_out  out  1  upstream holds all *_in values while high.
REQ-008 mem_req out 1; mem_we out 1; mem_addr out 12; mem_wdata out 12; mem_ack in 1; mem_rdata in 12: data-memory request/acknowledge port.
REQ-009 enable_out out 1; pc_out, instr_out, result_out out 12 each; instr_set_out, flags_out, reg_waddr_out out 4 each: registered bundle to write-back stage.
REQ-010 mem_fault  out  1  one-cycle pulse, memory timeout (see Configuration).

Function
REQ-011 States SHALL be IDLE and WAIT only.
REQ-012 IDLE, enable_in=1, non-memory opcode: SHALL register the input bundle to outputs with enable_out=1 next cycle (latency 1); result_out=result_in.
REQ-013 IDLE, enable_in=1, load or store opcode: SHALL capture the bundle, assert mem_req, mem_addr=result_in, mem_we=1 for store/0 for load, mem_wdata=store_data_in, and enter WAIT; enable_out=0 next cycle.
REQ-014 WAIT: mem_req, mem_we, mem_addr, mem_wdata SHALL remain stable until the cycle mem_ack=1 inclusive; mem_req SHALL be 0 in the cycle after ack.
REQ-015 WAIT with mem_ack=1: SHALL present captured bundle next cycle with enable_out=1; result_out=mem_rdata for load, captured result_in for store; return to IDLE.
REQ-016 stall_out SHALL be 1 exactly while state=WAIT (combinational from state), including the ack cycle.
REQ-017 IDLE, enable_in=0: enable_out=0 next cycle; other outputs hold.
REQ-018 flush_in in IDLE: incoming instruction SHALL be discarded, no mem_req, enable_out=0.
REQ-019 flush_in in WAIT: bus request SHALL continue to ack (no cancellation); on ack, enable_out SHALL stay 0; flush is remembered in a sticky bit cleared on leaving WAIT.
REQ-020 Flush and mem_ack in the same cycle: output suppressed, return to IDLE.
REQ-021 Load/store classification SHALL use shared decode helpers on {instr_set_in, opcode=instr_in[11:8]}.

Reset
REQ-022 Async rst SHALL force state=IDLE, mem_req=0, mem_we=0, stall_out=0, enable_out=0, mem_fault=0, all data outputs to 0, flush-sticky and timeout counter to 0.
REQ-023 Reset during WAIT SHALL drop mem_req immediately, without waiting for ack.

Configuration
REQ-024 Macro STAGE4MA_TIMEOUT_EN defined: a 4-bit counter SHALL count WAIT cycles; when 16 WAIT cycles pass without ack, SHALL drop mem_req, pulse mem_fault for one cycle, emit enable_out=1 with result_out=12'hFFF (suppressed if flushed), return to IDLE.
REQ-025 Macro undefined: WAIT SHALL persist indefinitely; mem_fault tied 0; no counter logic.

Structure
REQ-026 Helpers mem_read_fn / mem_write_fn and load/store opcode constants SHALL live in the shared iset/opcodes headers beside reg_write_fn.
REQ-027 Timeout constant (16) SHALL be a named localparam; no sub-module required.

Verification
REQ-028 ALU op, result_in=12'h123, enable_in=1 -> next cycle enable_out=1, result_out=12'h123, no mem_req.
REQ-029 Load addr 12'h040, ack after 3 cycles with mem_rdata=12'hABC -> stall_out high 4 cycles, address stable, then result_out=12'hABC, enable_out=1.
REQ-030 Store addr 12'h010, data 12'h555, ack same cycle as entering WAIT -> mem_we=1, mem_wdata=12'h555, one-cycle stall, enable_out=1.
REQ-031 Load, flush_in on 2nd WAIT cycle, ack on 3rd -> request completes, enable_out remains 0.
REQ-032 rst asserted mid-WAIT -> mem_req and stall_out 0 without clock edge; all outputs reset values.
REQ-033 With STAGE4MA_TIMEOUT_EN, no ack -> mem_fault pulse after 16 WAIT cycles, result_out=12'hFFF, state IDLE.
